// File: rtl/pulse_pkg.sv
// pulse_pkg: default window/pulse/rate constants shared with the sensor, plus FSM state encoding
package pulse_pkg;
  localparam int DEF_WINDOW_CYCLES = 12_800_000;
  localparam int DEF_PULSE_WIDTH = 1450;
  localparam int DEF_MAX_RATE = 255;
  localparam int DEF_CNT_W = 32;
  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;
endpackage

// File: rtl/pulse_frac_acc.sv
// pulse_frac_acc: window counter + Bresenham accumulator; in: clk, rst, run, rate; out: fire (spread evenly), wrap (last window cycle)
module pulse_frac_acc #(
  parameter int WINDOW_CYCLES = pulse_pkg::DEF_WINDOW_CYCLES,
  parameter int CNT_W = pulse_pkg::DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [7:0] rate,
  output logic       fire,
  output logic       wrap
);
  logic [CNT_W-1:0] cnt, acc, sum;
  assign sum = acc + CNT_W'(rate);
  assign fire = run && sum >= CNT_W'(WINDOW_CYCLES);
  assign wrap = run && cnt == CNT_W'(WINDOW_CYCLES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      acc <= '0;
    end else begin
      cnt <= (!run || wrap) ? '0 : cnt + CNT_W'(1);
      acc <= (!run || wrap) ? '0 : fire ? sum - CNT_W'(WINDOW_CYCLES) : sum;
    end
endmodule

// File: rtl/pulse_synth.sv
// pulse_synth: N-pulses-per-window generator; in: clk, reset_count, enable_i, rate_i/rate_valid_i; out: rate_ready_o, pulse_o, window_o, pulse_cnt_o, active_rate_o, overrun_o
module pulse_synth
  import pulse_pkg::*;
#(
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int PULSE_WIDTH = DEF_PULSE_WIDTH,
  parameter int MAX_RATE = DEF_MAX_RATE,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset_count,
  input  logic       enable_i,
  input  logic [7:0] rate_i,
  input  logic       rate_valid_i,
  output logic       rate_ready_o,
  output logic       pulse_o,
  output logic       window_o,
  output logic [7:0] pulse_cnt_o,
  output logic [7:0] active_rate_o,
  output logic       overrun_o
);
  state_t state, state_n;
  logic fire, wrap, run, start, drop, width_done, take, apply, shadow_full;
  logic [7:0] shadow, rate_cl, cnt_base;
  logic [CNT_W-1:0] wcnt;
  assign run = state != IDLE;
  assign take = rate_valid_i && rate_ready_o;
  assign apply = shadow_full && (state == IDLE || wrap);
  assign rate_cl = rate_i > 8'(MAX_RATE) ? 8'(MAX_RATE) : rate_i;
  assign rate_ready_o = !shadow_full;
  pulse_frac_acc #(.WINDOW_CYCLES(WINDOW_CYCLES), .CNT_W(CNT_W)) u_acc (
    .clk(clk),
    .rst(reset_count),
    .run(run),
    .rate(active_rate_o),
    .fire(fire),
    .wrap(wrap)
  );
  always_ff @(posedge clk or posedge reset_count)
    if (reset_count) begin
      shadow <= '0;
      shadow_full <= 1'b0;
      active_rate_o <= '0;
    end else if (take) begin
      shadow <= rate_cl;
      shadow_full <= 1'b1;
    end else if (apply) begin
      active_rate_o <= shadow;
      shadow_full <= 1'b0;
    end
  always_ff @(posedge clk or posedge reset_count)
    if (reset_count) begin
      state <= IDLE;
      wcnt <= '0;
      pulse_o <= 1'b0;
      window_o <= 1'b0;
      pulse_cnt_o <= '0;
      overrun_o <= 1'b0;
    end else begin
      state <= state_n;
      wcnt <= (state == HIGH && !width_done) ? wcnt + CNT_W'(1) : '0;
      pulse_o <= state_n == HIGH;
      window_o <= wrap;
      pulse_cnt_o <= !run ? '0 : cnt_base + {7'd0, start && cnt_base != 8'hFF};
      overrun_o <= overrun_o || drop;
    end
  always_comb begin
    state_n = state == IDLE ? (enable_i ? LOW : IDLE)
            : state == LOW  ? (!enable_i ? IDLE : fire ? HIGH : LOW)
            : (!width_done ? HIGH : enable_i ? LOW : IDLE);
  end
  // the count keeps its final value through the window_o cycle, then restarts
  always_comb begin
    start = state == LOW && enable_i && fire;
    drop = state == HIGH && fire;
    width_done = wcnt == CNT_W'(PULSE_WIDTH - 1);
    cnt_base = window_o ? 8'd0 : pulse_cnt_o;
  end
endmodule

// File: tb/tb_pulse_synth.sv
// tb_pulse_synth: scoreboard bench for pulse_synth with a small window
module tb_pulse_synth;
  localparam int W = 100;
  localparam int PW = 3;
  localparam int MR = 16;
  logic clk = 0, reset_count, enable_i, rate_valid_i;
  logic [7:0] rate_i;
  logic rate_ready_o, pulse_o, window_o, overrun_o;
  logic [7:0] pulse_cnt_o, active_rate_o;
  int checks = 0, errs = 0;
  int rq[$];
  int cur_rate = 0, pos = 0, rises = 0, n_rise = 0, nwin = 0, last_rise_pos = 0, hi_len = 0, p;
  bit track = 0, prev = 0;
  pulse_synth #(.WINDOW_CYCLES(W), .PULSE_WIDTH(PW), .MAX_RATE(MR), .CNT_W(32)) dut (
    .clk(clk),
    .reset_count(reset_count),
    .enable_i(enable_i),
    .rate_i(rate_i),
    .rate_valid_i(rate_valid_i),
    .rate_ready_o(rate_ready_o),
    .pulse_o(pulse_o),
    .window_o(window_o),
    .pulse_cnt_o(pulse_cnt_o),
    .active_rate_o(active_rate_o),
    .overrun_o(overrun_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic bit fires(input int k, input int r);
    return ((k + 1) * r) / W > (k * r) / W;
  endfunction
  always @(negedge clk) begin
    if (prev && !pulse_o && !reset_count && hi_len > 0) chk("width", hi_len, PW);
    hi_len = pulse_o ? hi_len + 1 : 0;
    if (track) begin
      pos++;
      if (pulse_o && !prev) begin
        p = window_o ? W : pos;
        chk("rise_pos", int'(fires(p - 1, cur_rate)), 1);
        last_rise_pos = p;
        rises++;
        n_rise++;
      end
      if (window_o) begin
        chk("win_pos", pos, W);
        chk("win_cnt", int'(pulse_cnt_o), cur_rate);
        chk("cnt_rises", int'(pulse_cnt_o), rises);
        if (rq.size() > 0) cur_rate = rq.pop_front();
        chk("active_rate", int'(active_rate_o), cur_rate);
        chk("ready_after", int'(rate_ready_o), 1);
        pos = 0;
        rises = 0;
        nwin++;
      end
    end
    prev = pulse_o;
  end
  task automatic send_rate(input int r, input bit q);
    int n = 0;
    @(posedge clk); #1;
    rate_i = 8'(r);
    rate_valid_i = 1;
    @(negedge clk);
    for (n = 0; n < 300 && !rate_ready_o; n++) @(negedge clk);
    chk("rate_accept", int'(rate_ready_o), 1);
    if (q) rq.push_back(r > MR ? MR : r);
    @(posedge clk); #1;
    rate_valid_i = 0;
    @(negedge clk);
    chk("ready_drop", int'(rate_ready_o), 0);
  endtask
  task automatic wait_rise();
    int k0 = n_rise;
    for (int i = 0; i < 300 && n_rise == k0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("rise_seen", int'(n_rise != k0), 1);
  endtask
  task automatic wait_win();
    int k0 = nwin;
    for (int i = 0; i < 300 && nwin == k0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("win_seen", int'(nwin != k0), 1);
  endtask
  task automatic start_run();
    @(posedge clk); #1;
    enable_i = 1;
    pos = -2;
    rises = 0;
    track = 1;
  endtask
  task automatic check_reset_vals(input string tag);
    chk({tag, "_pulse"}, int'(pulse_o), 0);
    chk({tag, "_window"}, int'(window_o), 0);
    chk({tag, "_cnt"}, int'(pulse_cnt_o), 0);
    chk({tag, "_active"}, int'(active_rate_o), 0);
    chk({tag, "_overrun"}, int'(overrun_o), 0);
    chk({tag, "_ready"}, int'(rate_ready_o), 1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    rate_i = 0;
    rate_valid_i = 0;
    enable_i = 0;
    reset_count = 1;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk); #1;
    reset_count = 0;
    send_rate(4, 0);
    repeat (2) @(negedge clk);
    chk("idle_apply", int'(active_rate_o), 4);
    chk("idle_ready", int'(rate_ready_o), 1);
    cur_rate = 4;
    start_run();
    wait_rise();
    chk("first_rise", last_rise_pos, 25);
    repeat (35) @(negedge clk);
    send_rate(16, 1);
    wait_win();
    repeat (50) @(negedge clk);
    send_rate(200, 1);
    wait_win();
    repeat (50) @(negedge clk);
    send_rate(0, 1);
    wait_win();
    repeat (50) @(negedge clk);
    send_rate(4, 1);
    wait_win();
    chk("overrun", int'(overrun_o), 0);
    wait_rise();
    chk("w5_rise", last_rise_pos, 25);
    @(posedge clk); #1;
    enable_i = 0;
    track = 0;
    @(negedge clk);
    chk("hold2", int'(pulse_o), 1);
    @(negedge clk);
    chk("hold3", int'(pulse_o), 1);
    @(negedge clk);
    chk("fall", int'(pulse_o), 0);
    repeat (3) @(negedge clk);
    chk("idle_pulse", int'(pulse_o), 0);
    chk("idle_cnt", int'(pulse_cnt_o), 0);
    start_run();
    wait_rise();
    chk("reenable_rise", last_rise_pos, 25);
    send_rate(8, 0);
    wait_rise();
    chk("pre_reset_pulse", int'(pulse_o), 1);
    track = 0;
    #2;
    reset_count = 1;
    #1;
    check_reset_vals("async");
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    reset_count = 0;
    repeat (3) @(negedge clk);
    chk("shadow_lost", int'(active_rate_o), 0);
    chk("post_ready", int'(rate_ready_o), 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
